i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio output stage fed by the clock-divider enables. It takes 16-bit stereo sample pairs from the NCO/mixer over a valid/ready handshake and drives a Philips-format I2S link (BCLK, LRCLK, SDATA). All three outputs are registered in the 24.576 MHz `master_clk` domain, using the 1.536 MHz `bit_clk_en` and 48 kHz `sample_clk_en` pulses. Each frame carries 32 BCLK slots: 16 for the left channel and 16 for the right.

## Interface
- `SAMPLE_W`, 16: input sample width; legal range 8..16. The sample is MSB-aligned in the 16-bit slot and unused LSBs are sent as 0.
- `master_clk` in 1: 24.576 MHz system clock; the only clock.
- `rst` in 1: synchronous reset, active-high.
- `bit_clk_en` in 1: one-cycle pulse every 16 `master_clk` cycles.
- `sample_clk_en` in 1: one-cycle pulse every 512 cycles; nominally coincident with `bit_clk_en`.
- `sample_l` in SAMPLE_W: left sample, two's complement.
- `sample_r` in SAMPLE_W: right sample, two's complement.
- `sample_valid` in 1: the sample pair is valid.
- `sample_ready` out 1: the holding register is empty; transfer occurs when valid and ready are both high.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrclk` out 1: word select; 0 = left, 1 = right.
- `i2s_sdata` out 1: serial data, MSB first.
- `underrun` out 1: one-cycle pulse when a frame starts with an empty holding register.
- `sync_err` out 1: sticky flag for enable misalignment; cleared only by `rst`.

## Operation
- **Holding register** (one entry, `{L,R}`):
  - A transfer sets it full.
  - A frame start moves its contents to the shifter and sets it empty.
  - There is no bypass. A transfer in the same cycle as a frame start fills the register for the next frame. The frame being started uses the pre-cycle contents (zeros plus `underrun` if the register was empty).
- **Slot counter**: 5 bits; advances on `bit_clk_en`.
- **`running` flag**: 0 after reset.
- **Frame start** occurs on a cycle with `bit_clk_en`=1 and either of:
  - `sample_clk_en`=1, or
  - `running`=1 and slot==31.
- **At frame start**: slot←0, `running`←1, shifter←`{L,R}`, or 32'h0 if the holding register is empty.
- **Slot contents** (W = current frame word):
  - Slot n = 1..31 → SDATA = W[32-n].
  - Slot 0 → SDATA = W_prev[0], i.e. the previous right LSB; one-BCLK I2S delay.
- **LRCLK**: 0 for slots 0..15, 1 for slots 16..31.
- **`sync_err` is set on** either:
  - `sample_clk_en`=1 with `bit_clk_en`=0, or
  - `running`=1 and (`sample_clk_en`&`bit_clk_en`) disagrees with slot==31.

  In the `sample_clk_en`+`bit_clk_en` case the block realigns: frame start is taken.
- **Before the first frame start**: BCLK toggles, while LRCLK=0 and SDATA=0.
- **Reset mid-frame**: the frame is abandoned; all outputs return to reset values on the next edge; the held sample is discarded.

## Timing
- **Reset values**: bclk=0, lrclk=0, sdata=0, sample_ready=0, underrun=0, sync_err=0, `running`=0, holding register empty.
- `sample_ready` goes to 1 in the first cycle after `rst` deasserts.
- **BCLK**, for a `bit_clk_en` pulse at cycle t:
  - bclk=0 for cycles t+1..t+8.
  - bclk=1 for cycles t+9..t+16.
  - Generated by a 3-bit half-period counter restarted by each pulse.
- **Data and word select**: sdata and lrclk update at t+1, on the BCLK falling edge. They are stable across the rising edge at t+9.
- **`underrun`**: high only in cycle t+1 of the frame-start pulse.
- **`sample_ready`**:
  - Falls in the cycle after a transfer.
  - Rises in the cycle after frame start.

## Structure
- **Package `i2s_pkg`**:
  - `SLOTS_PER_FRAME`=32
  - `SLOT_W`=16
  - `BCLK_HALF`=8
  - `typedef struct packed {logic [15:0] l, r;} stereo_t`
- **Sub-module `i2s_bclk_gen`**: half-period counter plus bclk register; outputs `bclk` and a `bclk_fall` strobe.
- **Top level**: holding register, slot counter, shifter, prev-LSB bit, and sync check.

## Test plan
- **Reset**: hold rst 3 cycles → all outputs 0; sample_ready=1 in the cycle after release.
- **BCLK shape**: bit_clk_en at t → bclk 0 at t+1..t+8, 1 at t+9..t+16; period 16 cycles.
- **Data frame**: push L=16'hA5C3, R=16'h1234, then run one frame:
  - Slots 1..16 = A5C3 MSB-first.
  - Slots 17..31 plus next-frame slot 0 = 1234.
  - lrclk 0 for slots 0..15, 1 for slots 16..31.
- **Underrun**: no push before a frame start → underrun pulses 1 cycle at t+1; the frame's 32 data bits are 0; the next-frame slot 0 carries 0.
- **Backpressure**: push two pairs within one frame → the second waits with sample_ready=0 until frame start; it is accepted the cycle after; no data is lost.
- **Misalignment**: assert sample_clk_en+bit_clk_en at slot 10 → sync_err=1 (sticky); slot restarts at 0 and the held pair loads.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and the stereo sample type for the I2S transmitter.
package i2s_pkg;
  localparam int SLOTS_PER_FRAME = 32;
  localparam int SLOT_W          = 16;
  localparam int BCLK_HALF       = 8;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock generator: a half-period counter restarted by every bit_clk_en pulse.
module i2s_bclk_gen
  import i2s_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit_clk_en,
  output logic o_bclk,
  output logic o_bclk_fall
);
  localparam int CNT_W = $clog2(BCLK_HALF);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bclk;

  // Each pulse forces BCLK low; it then toggles every BCLK_HALF cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else if (i_bit_clk_en) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(BCLK_HALF - 1)) begin
        r_bclk <= ~r_bclk;
      end
    end
  end

  assign o_bclk      = r_bclk;
  assign o_bclk_fall = i_bit_clk_en;
endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-entry holding register, 32-slot frame shifter,
// one-BCLK data delay and enable alignment checking.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                i_master_clk,
  input  logic                i_rst,
  input  logic                i_bit_clk_en,
  input  logic                i_sample_clk_en,
  input  logic [SAMPLE_W-1:0] i_sample_l,
  input  logic [SAMPLE_W-1:0] i_sample_r,
  input  logic                i_sample_valid,
  output logic                o_sample_ready,
  output logic                o_i2s_bclk,
  output logic                o_i2s_lrclk,
  output logic                o_i2s_sdata,
  output logic                o_underrun,
  output logic                o_sync_err
);
  localparam int SLOT_CNT_W = $clog2(SLOTS_PER_FRAME);

  stereo_t               r_hold;
  logic                  r_hold_full;
  logic                  r_ready;
  logic [31:0]           r_shift;
  logic [SLOT_CNT_W-1:0] r_slot;
  logic                  r_running;
  logic                  r_prev_lsb;
  logic                  r_sdata;
  logic                  r_lrclk;
  logic                  r_underrun;
  logic                  r_sync_err;

  logic                  w_xfer;
  logic                  w_slot_last;
  logic                  w_frame_start;
  logic                  w_sync_bad;
  logic                  w_hold_full_next;
  logic [SLOT_CNT_W-1:0] w_slot_next;
  stereo_t               w_pair;
  stereo_t               w_next_word;
  logic                  w_bclk_fall;

  i2s_bclk_gen u_bclk (
    .i_clk        (i_master_clk),
    .i_rst        (i_rst),
    .i_bit_clk_en (i_bit_clk_en),
    .o_bclk       (o_i2s_bclk),
    .o_bclk_fall  (w_bclk_fall)
  );

  assign w_pair.l = SLOT_W'(i_sample_l) << (SLOT_W - SAMPLE_W);
  assign w_pair.r = SLOT_W'(i_sample_r) << (SLOT_W - SAMPLE_W);

  assign w_xfer           = i_sample_valid & r_ready;
  assign w_slot_last      = (r_slot == SLOT_CNT_W'(SLOTS_PER_FRAME - 1));
  assign w_slot_next      = r_slot + 1'b1;
  assign w_frame_start    = w_bclk_fall & (i_sample_clk_en | (r_running & w_slot_last));
  assign w_sync_bad       = (i_sample_clk_en & ~i_bit_clk_en)
                          | (r_running & i_bit_clk_en & (i_sample_clk_en != w_slot_last));
  assign w_next_word      = r_hold_full ? r_hold : '0;
  // No bypass: a same-cycle transfer refills the register for the following frame.
  assign w_hold_full_next = w_xfer | (r_hold_full & ~w_frame_start);

  always_ff @(posedge i_master_clk) begin
    if (i_rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b0;
      r_shift     <= '0;
      r_slot      <= '0;
      r_running   <= 1'b0;
      r_prev_lsb  <= 1'b0;
      r_sdata     <= 1'b0;
      r_lrclk     <= 1'b0;
      r_underrun  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_hold_full <= w_hold_full_next;
      r_ready     <= ~w_hold_full_next;
      r_underrun  <= w_frame_start & ~r_hold_full;
      if (w_xfer) begin
        r_hold <= w_pair;
      end
      if (w_sync_bad) begin
        r_sync_err <= 1'b1;
      end
      // Slot 0 carries the previous word's LSB, giving the one-BCLK I2S delay.
      if (w_frame_start) begin
        r_slot     <= '0;
        r_running  <= 1'b1;
        r_shift    <= w_next_word;
        r_prev_lsb <= w_next_word.r[0];
        r_sdata    <= r_prev_lsb;
        r_lrclk    <= 1'b0;
      end else if (w_bclk_fall && r_running) begin
        r_slot  <= w_slot_next;
        r_sdata <= r_shift[31];
        r_shift <= {r_shift[30:0], 1'b0};
        r_lrclk <= w_slot_next[SLOT_CNT_W-1];
      end
    end
  end

  assign o_sample_ready = r_ready;
  assign o_i2s_lrclk    = r_lrclk;
  assign o_i2s_sdata    = r_sdata;
  assign o_underrun     = r_underrun;
  assign o_sync_err     = r_sync_err;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame vector table, randomized traffic against
// a slot-indexed reference model, and hand-written alignment/reset sequences.
module tb_i2s_tx;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst, bitEn, sampEn, valid;
  logic [SW-1:0] sl, sr;
  logic          ready, bclk, lrclk, sdata, underrun, syncErr;

  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_W(SW)) dut (
    .i_master_clk    (clk),
    .i_rst           (rst),
    .i_bit_clk_en    (bitEn),
    .i_sample_clk_en (sampEn),
    .i_sample_l      (sl),
    .i_sample_r      (sr),
    .i_sample_valid  (valid),
    .o_sample_ready  (ready),
    .o_i2s_bclk      (bclk),
    .o_i2s_lrclk     (lrclk),
    .o_i2s_sdata     (sdata),
    .o_underrun      (underrun),
    .o_sync_err      (syncErr)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          push;
    bit          expUnder;
    logic [31:0] expBits;
  } frameVec_t;

  frameVec_t   vecs[5];
  logic [31:0] got[8];
  bit          urSeen[8];
  bit          collect;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int phase   = 0;
  bit extraSamp = 0;

  bit          mRst, mRunning, mHoldFull, mReady, mUnderrun, mSyncErr, mSlot0Bit, mBclkKnown, lastXfer;
  logic [31:0] mHold, mWord;
  int          mSlot, mSinceBit, mSinceFs, mFrameCount, lastXferSinceFs;

  function automatic logic [15:0] alignS(logic [SW-1:0] x);
    return 16'(x) << (16 - SW);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: state advances once per clock from the sampled inputs.
  task automatic modelStep();
    bit xfer, fs;
    lastXfer = 0;
    if (rst) begin
      mRst = 1; mRunning = 0; mHoldFull = 0; mReady = 0; mUnderrun = 0; mSyncErr = 0;
      mSlot0Bit = 0; mBclkKnown = 0; mHold = '0; mWord = '0; mSlot = 0;
      mSinceBit = 1; mSinceFs = 1000; mFrameCount = 0;
    end else begin
      mRst = 0;
      xfer = valid && mReady;
      fs   = bitEn && (sampEn || (mRunning && mSlot == 31));
      if ((sampEn && !bitEn) || (mRunning && bitEn && (sampEn != (mSlot == 31)))) mSyncErr = 1;
      if (xfer) begin lastXfer = 1; lastXferSinceFs = mSinceFs; end
      mUnderrun = fs && !mHoldFull;
      if (fs) begin
        mSlot0Bit = mWord[0];
        mWord     = mHoldFull ? mHold : 32'h0;
        mSlot     = 0;
        mRunning  = 1;
        mHoldFull = 0;
        mSinceFs  = 1;
        mFrameCount++;
      end else begin
        mSinceFs++;
        if (bitEn && mRunning) mSlot++;
      end
      if (xfer) begin mHold = {alignS(sl), alignS(sr)}; mHoldFull = 1; end
      mReady = !mHoldFull;
      if (bitEn) begin mSinceBit = 1; mBclkKnown = 1; end
      else mSinceBit++;
    end
  endtask

  task automatic checkOutput();
    logic expSd, expLr, expBclk;
    expLr   = mRunning && (mSlot >= 16);
    expSd   = !mRunning ? 1'b0 : (mSlot == 0 ? mSlot0Bit : mWord[32 - mSlot]);
    expBclk = mRst ? 1'b0 : 1'(((mSinceBit - 1) / 8) % 2);
    check("ready", 32'(ready), 32'(mReady));
    check("underrun", 32'(underrun), 32'(mUnderrun));
    check("syncErr", 32'(syncErr), 32'(mSyncErr));
    check("lrclk", 32'(lrclk), 32'(expLr));
    check("sdata", 32'(sdata), 32'(expSd));
    if (mRst || mBclkKnown) check("bclk", 32'(bclk), 32'(expBclk));
  endtask

  task automatic applyStimulus();
    bitEn  = (phase % 16 == 0);
    sampEn = (phase % 512 == 0) || extraSamp;
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    phase++;
    extraSamp = 0;
    checkOutput();
    if (collect && mRunning && mSinceBit == 9) begin
      if (mSlot == 0) begin
        if (mFrameCount >= 2 && mFrameCount - 2 < 8) got[mFrameCount - 2][0] = sdata;
      end else if (mFrameCount - 1 < 8) begin
        got[mFrameCount - 1][32 - mSlot] = sdata;
      end
    end
    if (collect && underrun === 1'b1 && mFrameCount >= 1 && mFrameCount - 1 < 8) urSeen[mFrameCount - 1] = 1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pushPair(logic [15:0] l, logic [15:0] r, string name);
    int guard = 0;
    valid = 1; sl = l; sr = r;
    do begin applyStimulus(); guard++; end while (!lastXfer && guard < 1200);
    if (!lastXfer) check({name, "Timeout"}, 0, 1);
    valid = 0;
  endtask

  task automatic waitFrameCount(int n, string name);
    int guard = 0;
    while (mFrameCount < n && guard < 1200) begin applyStimulus(); guard++; end
    if (mFrameCount < n) check({name, "Timeout"}, 32'(mFrameCount), 32'(n));
  endtask

  initial begin
    int guard, waited, preSinceFs;
    bit seenReady;
    vecs[0] = '{16'hA5C3, 16'h1234, 1'b1, 1'b0, 32'hA5C31234};
    vecs[1] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 32'h00000000};
    vecs[2] = '{16'h8001, 16'h7FFE, 1'b1, 1'b0, 32'h80017FFE};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 32'hFFFF0001};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 32'h00000000};
    for (int i = 0; i < 8; i++) begin got[i] = 'x; urSeen[i] = 0; end
    collect = 0;
    rst = 1; valid = 0; sl = '0; sr = '0; bitEn = 0; sampEn = 0;
    #1;

    ticks(3);
    rst = 0;
    phase = 512 - 48;
    applyStimulus();
    check("readyAfterRst", 32'(ready), 1);

    // Frame vector table: one pair (or none) per frame, collected at BCLK rising edges.
    collect = 1;
    for (int k = 0; k < 5; k++) begin
      waitFrameCount(k, "tblFrame");
      if (vecs[k].push) pushPair(vecs[k].l, vecs[k].r, "tblPush");
    end
    waitFrameCount(6, "tblDrain");
    ticks(20);
    collect = 0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("frameBits%0d", k), got[k], vecs[k].expBits);
      check($sformatf("frameUnderrun%0d", k), 32'(urSeen[k]), 32'(vecs[k].expUnder));
    end

    // Randomized traffic: pairs arrive at random times, some frames underrun.
    for (int i = 0; i < 5000; i++) begin
      if (!valid && $urandom_range(0, 299) == 0) begin
        valid = 1; sl = SW'($urandom); sr = SW'($urandom);
      end
      applyStimulus();
      if (lastXfer) valid = 0;
    end
    valid = 0;

    // Backpressure: second pair waits for the next frame start.
    waitFrameCount(mFrameCount + 1, "bpSync");
    ticks(20);
    pushPair(16'h0F0F, 16'hF00D, "bpFirst");
    valid = 1; sl = 16'h3C3C; sr = 16'hBEEF;
    guard = 0; waited = 0; seenReady = 0; preSinceFs = -1;
    while (!seenReady && guard < 1200) begin
      seenReady  = (ready === 1'b1);
      preSinceFs = mSinceFs;
      if (!seenReady) waited++;
      applyStimulus();
      guard++;
    end
    valid = 0;
    check("bpAccepted", 32'(seenReady), 1);
    check("bpAcceptAfterFs", 32'(preSinceFs), 1);
    check("bpWaitedLong", 32'(waited > 100), 1);
    waitFrameCount(mFrameCount + 2, "bpDrain");

    // Misalignment: early sample_clk_en at slot 10 realigns the frame.
    pushPair(16'h5A5A, 16'hC001, "misPush");
    guard = 0;
    while (!(phase % 16 == 0 && mRunning && mSlot == 10) && guard < 1200) begin applyStimulus(); guard++; end
    check("misReachSlot10", 32'(mSlot), 10);
    phase = 0;
    applyStimulus();
    check("misSyncErr", 32'(syncErr), 1);
    check("misLrclk", 32'(lrclk), 0);
    check("misNoUnderrun", 32'(underrun), 0);
    check("misReadyAgain", 32'(ready), 1);
    ticks(600);
    check("misSticky", 32'(syncErr), 1);

    // Reset clears the sticky flag; then a sample_clk_en without bit_clk_en sets it.
    rst = 1; applyStimulus();
    rst = 0; ticks(5);
    check("syncClearedByRst", 32'(syncErr), 0);
    while (phase % 16 != 5) applyStimulus();
    extraSamp = 1;
    applyStimulus();
    check("syncErrNoBitEn", 32'(syncErr), 1);

    // Reset mid-frame abandons the frame and the held pair.
    pushPair(16'hFACE, 16'h0BAD, "midPush");
    guard = 0;
    while (!(mRunning && mSlot == 20) && guard < 1200) begin applyStimulus(); guard++; end
    check("midReachSlot20", 32'(mSlot), 20);
    pushPair(16'h1111, 16'h2222, "midHold");
    rst = 1; applyStimulus();
    check("midRstOutputs", {26'd0, bclk, lrclk, sdata, ready, underrun, syncErr}, 32'd0);
    rst = 0; ticks(600);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
